// File: rtl/btag_tracker_ss_if.sv
// Dispatch, completion-bus and branch-tag result signals of the branch-tag tracker.
interface btag_tracker_ss_if #(
    parameter int BS_SIZE        = 8,
    parameter int DISPATCH_WIDTH = 2,
    parameter int CDB_PORTS      = 2
);
    localparam int AW = $clog2(DISPATCH_WIDTH + 1);
    localparam int FW = $clog2(BS_SIZE + 1);

    logic                                     flush;
    logic [DISPATCH_WIDTH-1:0]                disp_valid;
    logic [DISPATCH_WIDTH-1:0]                disp_branch;
    logic [CDB_PORTS-1:0]                     cdb_valid;
    logic [CDB_PORTS-1:0]                     cdb_squash;
    logic [CDB_PORTS-1:0][BS_SIZE-1:0]        cdb_btag;
    logic [BS_SIZE-1:0]                       live_tags;
    logic [DISPATCH_WIDTH-1:0][BS_SIZE-1:0]   slot_tag;
    logic [DISPATCH_WIDTH-1:0][BS_SIZE-1:0]   slot_mask;
    logic [AW-1:0]                            disp_accept;
    logic                                     bs_stall;
    logic [FW-1:0]                            free_cnt;

    // Pipeline side: drives dispatch and completion, consumes tags.
    modport master (
        output flush, disp_valid, disp_branch, cdb_valid, cdb_squash, cdb_btag,
        input  live_tags, slot_tag, slot_mask, disp_accept, bs_stall, free_cnt
    );

    // Tracker side.
    modport slave (
        input  flush, disp_valid, disp_branch, cdb_valid, cdb_squash, cdb_btag,
        output live_tags, slot_tag, slot_mask, disp_accept, bs_stall, free_cnt
    );
endinterface

// File: rtl/btag_tracker_ss.sv
// Branch-tag tracker: one bit per in-flight branch, allocated downward from the
// lowest live bit (the frontier). Completions clear bits in the same cycle they
// arrive; mispredicts also clear every younger (lower-indexed) tag.
module btag_tracker_ss #(
    parameter int BS_SIZE        = 8,
    parameter int DISPATCH_WIDTH = 2,
    parameter int CDB_PORTS      = 2
) (
    input  logic              clock,
    input  logic              reset,
    btag_tracker_ss_if.slave  bus
);
    localparam int AW = $clog2(DISPATCH_WIDTH + 1);
    localparam int FW = $clog2(BS_SIZE + 1);

    logic [BS_SIZE-1:0]                     tags_reg;
    logic [BS_SIZE-1:0]                     tags_next;
    logic [FW-1:0]                          free_cnt_reg;
    logic [FW-1:0]                          free_cnt_next;

    logic [CDB_PORTS-1:0][BS_SIZE-1:0]      port_clear;
    logic [BS_SIZE-1:0]                     clear_all;
    logic [BS_SIZE-1:0]                     live;
    logic [FW-1:0]                          frontier;
    logic                                   block_disp;

    logic [DISPATCH_WIDTH-1:0][BS_SIZE-1:0] slot_tag_c;
    logic [DISPATCH_WIDTH-1:0][BS_SIZE-1:0] slot_mask_c;
    logic [BS_SIZE-1:0]                     grant_all;
    logic [AW-1:0]                          accept_cnt;
    logic [AW-1:0]                          valid_cnt;

    // Index of the lowest set bit; BS_SIZE when the vector is empty.
    function automatic logic [FW-1:0] lowest_set(input logic [BS_SIZE-1:0] v);
        logic [FW-1:0] idx;
        idx = FW'(BS_SIZE);
        for (int i = BS_SIZE - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = FW'(i);
            end
        end
        return idx;
    endfunction

    // Per-port clear vector: own bit on resolve, own bit and all younger on squash.
    // A zero tag means a non-branch completion and clears nothing.
    generate
        for (genvar gi = 0; gi < CDB_PORTS; gi++) begin : g_port
            assign port_clear[gi] =
                (!bus.cdb_valid[gi] || bus.cdb_btag[gi] == '0) ? '0 :
                bus.cdb_squash[gi] ? (bus.cdb_btag[gi] | (bus.cdb_btag[gi] - 1'b1)) :
                                     bus.cdb_btag[gi];
        end
    endgenerate

    // Merge completions into the live vector and locate the frontier.
    always_comb begin
        clear_all = '0;
        for (int p = 0; p < CDB_PORTS; p++) begin
            clear_all = clear_all | port_clear[p];
        end
        live       = tags_reg & ~clear_all;
        frontier   = lowest_set(live);
        block_disp = bus.flush | (|(bus.cdb_valid & bus.cdb_squash));
    end

    // Walk slots oldest-first, handing out frontier-1, frontier-2, ... to branches.
    always_comb begin
        logic [FW-1:0] pos;
        logic          stop;
        slot_tag_c  = '0;
        slot_mask_c = '0;
        grant_all   = '0;
        accept_cnt  = '0;
        valid_cnt   = '0;
        pos         = frontier;
        stop        = 1'b0;
        for (int s = 0; s < DISPATCH_WIDTH; s++) begin
            slot_mask_c[s] = live | grant_all;
            valid_cnt      = valid_cnt + AW'(bus.disp_valid[s]);
            if (!block_disp && !stop) begin
                if (!bus.disp_valid[s]) begin
                    stop = 1'b1;
                end else if (bus.disp_branch[s]) begin
                    if (pos == '0) begin
                        stop = 1'b1;
                    end else begin
                        pos           = pos - 1'b1;
                        slot_tag_c[s] = {{(BS_SIZE-1){1'b0}}, 1'b1} << pos;
                        grant_all     = grant_all | slot_tag_c[s];
                        accept_cnt    = accept_cnt + 1'b1;
                    end
                end else begin
                    accept_cnt = accept_cnt + 1'b1;
                end
            end
        end
    end

    // Next tag state: flush wipes everything, otherwise survivors plus new grants.
    always_comb begin
        tags_next     = bus.flush ? '0 : (live | grant_all);
        free_cnt_next = lowest_set(tags_next);
    end

    // State registers; reset dominates flush, dispatch and completion.
    always_ff @(posedge clock) begin
        if (reset) begin
            tags_reg     <= '0;
            free_cnt_reg <= FW'(BS_SIZE);
        end else begin
            tags_reg     <= tags_next;
            free_cnt_reg <= free_cnt_next;
        end
    end

    assign bus.live_tags   = live;
    assign bus.slot_tag    = slot_tag_c;
    assign bus.slot_mask   = slot_mask_c;
    assign bus.disp_accept = accept_cnt;
    assign bus.bs_stall    = !block_disp && (accept_cnt < valid_cnt);
    assign bus.free_cnt    = free_cnt_reg;
endmodule

// File: doc/btag_tracker_ss.md
BTAG_TRACKER_SS -- requirements
Module: btag_tracker_ss

Interface
REQ-001 SHALL have parameter: BS_SIZE, 8, branch-stack entries; one bit per tag, bit BS_SIZE-1 oldest position.
REQ-002 SHALL have parameter: DISPATCH_WIDTH, 2, instruction slots offered per cycle, slot 0 oldest.
REQ-003 SHALL have parameter: CDB_PORTS, 2, completion ports checked per cycle.
REQ-004 SHALL have port: clock  in  1  clock; reset  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port: flush  in  1  exception flush; clears all tags.
REQ-006 SHALL have port: disp_valid  in  DISPATCH_WIDTH  slot holds an instruction.
REQ-007 SHALL have port: disp_branch  in  DISPATCH_WIDTH  slot instruction is a branch.
REQ-008 SHALL have port: cdb_valid  in  CDB_PORTS  port carries a completed branch.
REQ-009 SHALL have port: cdb_squash  in  CDB_PORTS  completed branch mispredicted.
REQ-010 SHALL have port: cdb_btag  in  CDB_PORTS x BS_SIZE  one-hot tag of completed branch; zero = non-branch.
REQ-011 SHALL have port: live_tags  out  BS_SIZE  post-completion live vector this cycle (combinational).
REQ-012 SHALL have port: slot_tag  out  DISPATCH_WIDTH x BS_SIZE  one-hot tag granted to slot; zero if not a granted branch.
REQ-013 SHALL have port: slot_mask  out  DISPATCH_WIDTH x BS_SIZE  dependency mask for slot: live_tags OR tags granted to older slots; excludes own tag.
REQ-014 SHALL have port: disp_accept  out  $clog2(DISPATCH_WIDTH+1)  count of leading slots accepted.
REQ-015 SHALL have port: bs_stall  out  1  high when disp_accept < number of valid slots.
REQ-016 SHALL have port: free_cnt  out  $clog2(BS_SIZE+1)  registered count of allocatable positions below frontier.

Function
REQ-017 SHALL hold state register tags[BS_SIZE]; live_tags = tags with completions applied.
REQ-018 For each valid CDB port without squash, SHALL clear that port's tag bit.
REQ-019 For each valid CDB port with squash, SHALL clear its tag bit and all lower-indexed (younger) bits; multiple ports OR their clear vectors.
REQ-020 Zero cdb_btag SHALL clear nothing regardless of cdb_squash.
REQ-021 Frontier SHALL be lowest set index of live_tags; empty vector gives frontier BS_SIZE.
REQ-022 Granted tags SHALL be frontier-1, frontier-2, ... in slot order, one per accepted branch; tags never reuse holes above frontier.
REQ-023 Acceptance SHALL stop at the first valid branch slot with no position left (frontier reached 0); that slot and all younger slots rejected.
REQ-024 Non-branch slots before the stopping point SHALL be accepted; disp_valid=0 slots terminate the count.
REQ-025 If any cdb_valid&cdb_squash or flush, disp_accept SHALL be 0, no tags granted, bs_stall 0.
REQ-026 Next state SHALL be live_tags OR granted tags; flush SHALL load 0 (overrides all).
REQ-027 free_cnt SHALL register the frontier of next state (positions 0..frontier-1).
REQ-028 All outputs other than free_cnt SHALL be combinational within the same cycle; grant-to-visible latency 1 cycle.

Reset
REQ-029 On reset tags SHALL be 0 and free_cnt SHALL be BS_SIZE; reset overrides flush, dispatch, CDB.
REQ-030 Reset asserted mid-operation SHALL discard all live tags at the next edge.

Verification (BS_SIZE=4, DISPATCH_WIDTH=2, CDB_PORTS=2)
REQ-031 After reset, disp_valid=11, disp_branch=11 -> slot_tag0=1000, slot_tag1=0100, slot_mask1=1000, accept=2; next tags=1100, free_cnt=2.
REQ-032 tags=1110, disp_valid=11, disp_branch=11 -> slot_tag0=0001, accept=1, bs_stall=1; next tags=1111, free_cnt=0.
REQ-033 tags=1111, port0 squash tag 0100, port1 resolve 1000 -> live_tags=0000, accept=0; next free_cnt=4.
REQ-034 tags=1100, port0 resolve 0100, branch dispatch -> live_tags=1000, slot_tag0=0100; hole reuse at frontier only.
REQ-035 tags=1011, flush with dispatch valid -> accept=0; next tags=0000, free_cnt=4.
REQ-036 Random bench SHALL compare against reference model; check tags never hold a bit below frontier unallocated by grant.
